pic_ack_sequencer: RTL and testbench
====================================

Name: pic_ack_sequencer

Overview:
- Interrupt acknowledge sequencer for the PIC8259 core. Sits between the request/mask registers and the CPU-side control logic.
- Resolves priority under the fully nested scheme (IR0 highest, IR7 lowest) and raises INT.
- Sequences the two-pulse INTA cycle, sets the in-service bit, drives the 8086-mode vector, and clears in-service bits on EOI commands.
- Owns the in-service register state that the downstream ISR logic reads.

Parameters:
- NUM_IR, 8, number of interrupt levels. Fixed at 8; other values unsupported.
- SPURIOUS_LVL, 7, level reported on the vector when the request is withdrawn before the first INTA.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- irr  in  8  interrupt request register; bit n = IRn pending.
- imr  in  8  interrupt mask register; 1 = masked.
- inta  in  1  one-cycle pulse per CPU INTA pulse, already synchronized by control logic.
- eoi_valid  in  1  one-cycle EOI command strobe.
- eoi_specific  in  1  qualifies eoi_valid: 1 = specific EOI, 0 = non-specific.
- eoi_level  in  3  level cleared by a specific EOI.
- vector_base  in  5  ICW2 bits T7..T3.
- int_out  out  1  INT request to the CPU.
- data_out  out  8  vector byte.
- data_out_en  out  1  vector valid / bus drive enable.
- isr  out  8  in-service register.
- ack_level  out  3  level captured at the first INTA.

Behaviour:
- Reset: all outputs are 0; state = IDLE. Reset has priority over all other inputs and aborts any INTA sequence in progress.
- Priority resolution (combinational):
  - req = irr & ~imr.
  - cand = lowest-index set bit of req.
  - isr_top = lowest-index set bit of isr.
  - Request is eligible only if cand index < isr_top index, or isr == 0.
- int_out is registered: it rises one cycle after an eligible request appears.
- State machine:
  - IDLE: int_out = eligible. On an inta pulse, go to ACK1.
  - ACK1 (entry cycle):
    - If a request is eligible, capture ack_level = cand, set isr[cand], drop int_out.
    - If none is eligible, capture ack_level = SPURIOUS_LVL, leave isr unchanged, set spurious flag.
    - Then wait for the second inta.
  - ACK2: on the second inta, data_out = {vector_base, ack_level} and data_out_en = 1 for exactly one cycle; next state is IDLE.
- An inta arriving in IDLE while int_out = 0 is still treated as first INTA and follows the spurious path.
- The cycle after returning to IDLE re-evaluates priority; int_out may reassert immediately.
- Non-specific EOI clears the isr_top bit. It is a no-op if isr == 0.
- Specific EOI clears isr[eoi_level] regardless of priority.
- EOI and ISR set in the same cycle: the clear is applied first, then the set. If both target the same bit, the set wins.
- irr changes during ACK1/ACK2 do not alter ack_level or data_out.
- Masking a level after its ISR bit is set does not clear the bit.

Optional Feature:
- Macro: PIC_AEOI_EN.
- Defined: automatic EOI. In the cycle data_out_en is asserted, isr[ack_level] is cleared (unless spurious). Explicit EOI commands remain honoured.
- Undefined: isr bits clear only through eoi_valid.

Test Plan:
- Priority and vector: irr = 8'h24, imr = 0, vector_base = 5'h08. Expect:
  - int_out = 1 one cycle later.
  - First inta: isr = 8'h04.
  - Second inta: data_out = 8'h42, data_out_en for 1 cycle.
  - Non-specific EOI: isr = 0.
  - Then int_out reasserts for IR5.
- Nesting: isr = 8'h08 (IR3 in service), then irr = 8'h40 → int_out stays 0. Then irr = 8'h02 → int_out = 1 and the ack sets isr = 8'h0A.
- Spurious: irr = 8'h10 raises int_out; irr drops to 0 before the first inta. Expect isr unchanged, data_out = {vector_base, 3'b111}.
- Specific EOI with eoi_level = 3 while isr = 8'h0A → isr = 8'h02.
- Collision: non-specific EOI in the same cycle as the first inta for IR1, with isr = 8'h02 → isr = 8'h02 (set wins).
- Reset mid-sequence (in ACK2) → next cycle isr = 0, int_out = 0, data_out_en = 0, state IDLE. With PIC_AEOI_EN defined, the IR2 ack leaves isr = 0 after the vector cycle.

Source files
------------

// File: rtl/pic_ack_sequencer_if.sv
// -----------------------------------------------------------------------------
// pic_ack_sequencer_if
//
// Purpose: bundles the request/mask inputs, the CPU acknowledge and EOI
// controls, and the vector/in-service outputs of the PIC8259 acknowledge
// sequencer. Clock and reset stay outside as plain ports.
//
// Signals (direction given from the sequencer's point of view):
//   irr[7:0]          in   interrupt request register, bit n = IRn pending
//   imr[7:0]          in   interrupt mask register, 1 = masked
//   inta              in   one-cycle pulse per CPU INTA pulse (synchronized)
//   eoi_valid         in   one-cycle EOI command strobe
//   eoi_specific      in   1 = specific EOI, 0 = non-specific
//   eoi_level[2:0]    in   level cleared by a specific EOI
//   vector_base[4:0]  in   ICW2 bits T7..T3
//   int_out           out  INT request to the CPU
//   data_out[7:0]     out  vector byte
//   data_out_en       out  vector valid / bus drive enable
//   isr[7:0]          out  in-service register
//   ack_level[2:0]    out  level captured at the first INTA
//
// Modports: master = control logic driving the sequencer, slave = sequencer.
// -----------------------------------------------------------------------------
interface pic_ack_sequencer_if;
  logic [7:0] irr;
  logic [7:0] imr;
  logic       inta;
  logic       eoi_valid;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic [4:0] vector_base;
  logic       int_out;
  logic [7:0] data_out;
  logic       data_out_en;
  logic [7:0] isr;
  logic [2:0] ack_level;

  modport master (
    output irr, imr, inta, eoi_valid, eoi_specific, eoi_level, vector_base,
    input  int_out, data_out, data_out_en, isr, ack_level
  );

  modport slave (
    input  irr, imr, inta, eoi_valid, eoi_specific, eoi_level, vector_base,
    output int_out, data_out, data_out_en, isr, ack_level
  );
endinterface

// File: rtl/pic_ack_sequencer.sv
// -----------------------------------------------------------------------------
// pic_ack_sequencer
//
// Purpose: interrupt acknowledge sequencer for the PIC8259 core. Resolves
// fully nested priority (IR0 highest, IR7 lowest), raises INT, sequences the
// two-pulse INTA cycle, sets the in-service bit on the first INTA, drives the
// 8086-mode vector on the second INTA, and clears in-service bits on EOI.
//
// Ports:
//   clk    in  system clock, all state updates on the rising edge
//   reset  in  synchronous, active-high reset
//   bus    slave modport of pic_ack_sequencer_if (request, mask, INTA, EOI,
//          vector base in; INT, vector, vector enable, ISR, ack level out)
//
// Parameters:
//   NUM_IR        number of interrupt levels, fixed at 8
//   SPURIOUS_LVL  level reported when the request vanished before first INTA
//
// Build option: define PIC_AEOI_EN for automatic EOI (the acknowledged ISR
// bit is cleared as the vector is presented, except for spurious acks).
//
// Timing: the first INTA is acted on at the edge that samples it (level
// capture, ISR set, INT dropped). The vector appears, registered, for the one
// cycle following the edge that samples the second INTA.
// -----------------------------------------------------------------------------
module pic_ack_sequencer #(
  parameter int NUM_IR       = 8,
  parameter int SPURIOUS_LVL = 7
) (
  input  logic                clk,
  input  logic                reset,
  pic_ack_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // waiting for a first INTA, INT follows eligibility
    S_ACK1 = 2'd1,  // entry cycle after the first INTA
    S_ACK2 = 2'd2   // waiting for the second INTA
  } state_e;

  state_e            state_q, state_d;
  logic [NUM_IR-1:0] isr_q, isr_d;
  logic              int_out_q, int_out_d;
  logic [2:0]        ack_level_q, ack_level_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              data_out_en_q, data_out_en_d;

  logic [NUM_IR-1:0] req;
  logic [NUM_IR-1:0] eoi_clr;
  logic [NUM_IR-1:0] aeoi_clr;
  logic [NUM_IR-1:0] isr_eff;
  logic              cand_vld, top_vld, eff_top_vld;
  logic [2:0]        cand_idx, top_idx, eff_top_idx;
  logic              eligible;
  logic              second_inta;

  // Returns {found, index} of the lowest-index (highest-priority) set bit.
  function automatic logic [3:0] lowest_set(input logic [NUM_IR-1:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      if (v[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  assign second_inta = (state_q != S_IDLE) && bus.inta;

`ifdef PIC_AEOI_EN
  // Remembers whether the current ack took the spurious path, so automatic
  // EOI leaves the ISR alone for it.
  logic spurious_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      spurious_q <= 1'b0;
    end else if (state_q == S_IDLE && bus.inta) begin
      spurious_q <= !eligible;
    end
  end

  always_comb begin
    aeoi_clr = '0;
    if (second_inta && !spurious_q) aeoi_clr[ack_level_q] = 1'b1;
  end
`else
  assign aeoi_clr = '0;
`endif

  // Clears are resolved first; the post-clear ISR feeds priority so that an
  // EOI arriving with the first INTA frees the level it targets before the
  // new in-service bit is chosen.
  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    req                      = bus.irr & ~bus.imr;
    {top_vld, top_idx}       = lowest_set(isr_q);
    eoi_clr                  = '0;
    if (bus.eoi_valid) begin
      if (bus.eoi_specific) eoi_clr[bus.eoi_level] = 1'b1;
      else if (top_vld)     eoi_clr[top_idx]       = 1'b1;
    end
    isr_eff                  = isr_q & ~eoi_clr & ~aeoi_clr;
    {cand_vld, cand_idx}     = lowest_set(req);
    {eff_top_vld, eff_top_idx} = lowest_set(isr_eff);
    eligible = cand_vld && (!eff_top_vld || (cand_idx < eff_top_idx));
  end

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    isr_d         = isr_eff;
    int_out_d     = 1'b0;
    ack_level_d   = ack_level_q;
    data_out_d    = '0;
    data_out_en_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.inta) begin
          state_d = S_ACK1;
          if (eligible) begin
            ack_level_d    = cand_idx;
            isr_d[cand_idx] = 1'b1;  // set after clear: set wins on a tie
          end else begin
            ack_level_d = 3'(SPURIOUS_LVL);
          end
        end else begin
          int_out_d = eligible;
        end
      end

      // A second INTA is accepted in either ack state; ACK1 only marks the
      // entry cycle and otherwise falls through to ACK2.
      S_ACK1, S_ACK2: begin
        if (second_inta) begin
          state_d       = S_IDLE;
          data_out_d    = {bus.vector_base, ack_level_q};
          data_out_en_d = 1'b1;
        end else begin
          state_d = S_ACK2;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      isr_q         <= '0;
      int_out_q     <= 1'b0;
      ack_level_q   <= '0;
      data_out_q    <= '0;
      data_out_en_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      isr_q         <= isr_d;
      int_out_q     <= int_out_d;
      ack_level_q   <= ack_level_d;
      data_out_q    <= data_out_d;
      data_out_en_q <= data_out_en_d;
    end
  end

  assign bus.int_out     = int_out_q;
  assign bus.data_out    = data_out_q;
  assign bus.data_out_en = data_out_en_q;
  assign bus.isr         = isr_q;
  assign bus.ack_level   = ack_level_q;

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pic_ack_sequencer
//
// Directed bench for pic_ack_sequencer. Inputs change 2 ns after a rising
// edge and outputs are sampled at the same point, well away from the edge.
// Expected values are hand-computed from the behavioural description.
// -----------------------------------------------------------------------------
module tb_pic_ack_sequencer;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pic_ack_sequencer_if bus();

  pic_ack_sequencer #(.NUM_IR(8), .SPURIOUS_LVL(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic inta_pulse();
    bus.inta = 1'b1;
    step();
    bus.inta = 1'b0;
  endtask

  task automatic test_reset();
    reset            = 1'b1;
    bus.irr          = 8'h00;
    bus.imr          = 8'h00;
    bus.inta         = 1'b0;
    bus.eoi_valid    = 1'b0;
    bus.eoi_specific = 1'b0;
    bus.eoi_level    = 3'd0;
    bus.vector_base  = 5'h08;
    step();
    step();
    reset = 1'b0;
    step();
    checks++; if (bus.int_out !== 1'b0) begin errors++; $display("FAIL rst_int: got %b want 0", bus.int_out); end
    checks++; if (bus.isr !== 8'h00) begin errors++; $display("FAIL rst_isr: got %h want 00", bus.isr); end
    checks++; if (bus.data_out_en !== 1'b0) begin errors++; $display("FAIL rst_den: got %b want 0", bus.data_out_en); end
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL rst_dout: got %h want 00", bus.data_out); end
    checks++; if (bus.ack_level !== 3'd0) begin errors++; $display("FAIL rst_lvl: got %0d want 0", bus.ack_level); end
  endtask

  // IR2 and IR5 pending: IR2 wins, vector 0x08<<3 | 2 = 0x42.
  task automatic test_priority_vector();
    bus.irr = 8'h24;
    step();
    checks++; if (bus.int_out !== 1'b1) begin errors++; $display("FAIL pv_int: got %b want 1", bus.int_out); end
    inta_pulse();
    checks++; if (bus.isr !== 8'h04) begin errors++; $display("FAIL pv_isr: got %h want 04", bus.isr); end
    checks++; if (bus.ack_level !== 3'd2) begin errors++; $display("FAIL pv_lvl: got %0d want 2", bus.ack_level); end
    checks++; if (bus.int_out !== 1'b0) begin errors++; $display("FAIL pv_int_drop: got %b want 0", bus.int_out); end
    // IR2 withdrawn mid-sequence; captured level must not move.
    bus.irr = 8'h20;
    step();
    inta_pulse();
    checks++; if (bus.data_out_en !== 1'b1) begin errors++; $display("FAIL pv_den: got %b want 1", bus.data_out_en); end
    checks++; if (bus.data_out !== 8'h42) begin errors++; $display("FAIL pv_vec: got %h want 42", bus.data_out); end
    step();
    checks++; if (bus.data_out_en !== 1'b0) begin errors++; $display("FAIL pv_den_1cyc: got %b want 0", bus.data_out_en); end
    // IR5 is below the in-service IR2.
    checks++; if (bus.int_out !== 1'b0) begin errors++; $display("FAIL pv_int_nested: got %b want 0", bus.int_out); end
    bus.eoi_valid    = 1'b1;
    bus.eoi_specific = 1'b0;
    step();
    bus.eoi_valid    = 1'b0;
    checks++; if (bus.isr !== 8'h00) begin errors++; $display("FAIL pv_eoi_isr: got %h want 00", bus.isr); end
    step();
    checks++; if (bus.int_out !== 1'b1) begin errors++; $display("FAIL pv_int_ir5: got %b want 1", bus.int_out); end
  endtask

  // Put IR3 in service, then check lower and higher priority requests.
  task automatic test_nesting();
    bus.irr = 8'h08;
    step();
    inta_pulse();
    checks++; if (bus.isr !== 8'h08) begin errors++; $display("FAIL nest_isr3: got %h want 08", bus.isr); end
    bus.irr = 8'h00;
    step();
    inta_pulse();
    checks++; if (bus.data_out !== 8'h43) begin errors++; $display("FAIL nest_vec3: got %h want 43", bus.data_out); end
    bus.irr = 8'h40;
    step();
    step();
    checks++; if (bus.int_out !== 1'b0) begin errors++; $display("FAIL nest_ir6_blocked: got %b want 0", bus.int_out); end
    bus.irr = 8'h02;
    step();
    checks++; if (bus.int_out !== 1'b1) begin errors++; $display("FAIL nest_ir1_int: got %b want 1", bus.int_out); end
    inta_pulse();
    checks++; if (bus.isr !== 8'h0A) begin errors++; $display("FAIL nest_isr: got %h want 0a", bus.isr); end
    bus.irr = 8'h00;
    step();
    inta_pulse();
    checks++; if (bus.data_out !== 8'h41) begin errors++; $display("FAIL nest_vec1: got %h want 41", bus.data_out); end
    step();
  endtask

  task automatic test_specific_eoi();
    bus.eoi_valid    = 1'b1;
    bus.eoi_specific = 1'b1;
    bus.eoi_level    = 3'd3;
    step();
    bus.eoi_valid    = 1'b0;
    bus.eoi_specific = 1'b0;
    checks++; if (bus.isr !== 8'h02) begin errors++; $display("FAIL seoi_isr: got %h want 02", bus.isr); end
  endtask

  // isr = 02, IR1 requests again: blocked until an EOI lands with the INTA.
  task automatic test_collision();
    bus.irr = 8'h02;
    step();
    checks++; if (bus.int_out !== 1'b0) begin errors++; $display("FAIL col_int: got %b want 0", bus.int_out); end
    bus.inta         = 1'b1;
    bus.eoi_valid    = 1'b1;
    bus.eoi_specific = 1'b0;
    step();
    bus.inta      = 1'b0;
    bus.eoi_valid = 1'b0;
    checks++; if (bus.isr !== 8'h02) begin errors++; $display("FAIL col_isr: got %h want 02", bus.isr); end
    checks++; if (bus.ack_level !== 3'd1) begin errors++; $display("FAIL col_lvl: got %0d want 1", bus.ack_level); end
    bus.irr = 8'h00;
    step();
    inta_pulse();
    checks++; if (bus.data_out !== 8'h41) begin errors++; $display("FAIL col_vec: got %h want 41", bus.data_out); end
    bus.eoi_valid = 1'b1;
    step();
    bus.eoi_valid = 1'b0;
    checks++; if (bus.isr !== 8'h00) begin errors++; $display("FAIL col_eoi: got %h want 00", bus.isr); end
  endtask

  // Request withdrawn before the first INTA: level 7, ISR untouched.
  task automatic test_spurious();
    bus.vector_base = 5'h15;
    bus.irr = 8'h10;
    step();
    checks++; if (bus.int_out !== 1'b1) begin errors++; $display("FAIL spur_int: got %b want 1", bus.int_out); end
    bus.irr = 8'h00;
    step();
    inta_pulse();
    checks++; if (bus.isr !== 8'h00) begin errors++; $display("FAIL spur_isr: got %h want 00", bus.isr); end
    checks++; if (bus.ack_level !== 3'd7) begin errors++; $display("FAIL spur_lvl: got %0d want 7", bus.ack_level); end
    step();
    inta_pulse();
    checks++; if (bus.data_out !== 8'hAF) begin errors++; $display("FAIL spur_vec: got %h want af", bus.data_out); end
    checks++; if (bus.data_out_en !== 1'b1) begin errors++; $display("FAIL spur_den: got %b want 1", bus.data_out_en); end
    step();
    bus.vector_base = 5'h08;
  endtask

  task automatic test_mask();
    bus.irr = 8'h01;
    bus.imr = 8'h01;
    step();
    step();
    checks++; if (bus.int_out !== 1'b0) begin errors++; $display("FAIL mask_int: got %b want 0", bus.int_out); end
    bus.imr = 8'h00;
    step();
    checks++; if (bus.int_out !== 1'b1) begin errors++; $display("FAIL unmask_int: got %b want 1", bus.int_out); end
    inta_pulse();
    bus.imr = 8'hFF;
    step();
    step();
    checks++; if (bus.isr !== 8'h01) begin errors++; $display("FAIL mask_keep_isr: got %h want 01", bus.isr); end
    inta_pulse();
    bus.imr = 8'h00;
    bus.irr = 8'h00;
    bus.eoi_valid = 1'b1;
    step();
    bus.eoi_valid = 1'b0;
    checks++; if (bus.isr !== 8'h00) begin errors++; $display("FAIL mask_eoi: got %h want 00", bus.isr); end
  endtask

  task automatic test_reset_mid_sequence();
    bus.irr = 8'h04;
    step();
    inta_pulse();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (bus.isr !== 8'h00) begin errors++; $display("FAIL rmid_isr: got %h want 00", bus.isr); end
    checks++; if (bus.int_out !== 1'b0) begin errors++; $display("FAIL rmid_int: got %b want 0", bus.int_out); end
    checks++; if (bus.data_out_en !== 1'b0) begin errors++; $display("FAIL rmid_den: got %b want 0", bus.data_out_en); end
    checks++; if (bus.ack_level !== 3'd0) begin errors++; $display("FAIL rmid_lvl: got %0d want 0", bus.ack_level); end
    // Back in IDLE: IR2 still pending, so INT reasserts next cycle.
    step();
    checks++; if (bus.int_out !== 1'b1) begin errors++; $display("FAIL rmid_idle_int: got %b want 1", bus.int_out); end
    // A second INTA would emit a vector if the sequence had survived reset.
    bus.irr = 8'h00;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

`ifdef PIC_AEOI_EN
  task automatic test_aeoi();
    bus.irr = 8'h04;
    step();
    inta_pulse();
    checks++; if (bus.isr !== 8'h04) begin errors++; $display("FAIL aeoi_set: got %h want 04", bus.isr); end
    bus.irr = 8'h00;
    step();
    inta_pulse();
    checks++; if (bus.data_out !== 8'h42) begin errors++; $display("FAIL aeoi_vec: got %h want 42", bus.data_out); end
    checks++; if (bus.isr !== 8'h00) begin errors++; $display("FAIL aeoi_clr: got %h want 00", bus.isr); end
    step();
    checks++; if (bus.isr !== 8'h00) begin errors++; $display("FAIL aeoi_after: got %h want 00", bus.isr); end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
`ifdef PIC_AEOI_EN
    test_aeoi();
    test_spurious();
    test_reset_mid_sequence();
`else
    test_priority_vector();
    test_nesting();
    test_specific_eoi();
    test_collision();
    test_spurious();
    test_mask();
    test_reset_mid_sequence();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
